// File: rtl/ntr_cmd_ctrl.sv
// Command controller: captures a 64-bit command on the rising edge of cmd_ready,
// decodes it, and either updates the LED or streams response bytes out.
module ntr_cmd_ctrl #(
  parameter logic [31:0] CHIP_ID  = 32'hC20F_0000,
  parameter int          READ_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cmd,
  input  logic        cmd_ready,
  output logic        led,
  output logic [7:0]  resp_data,
  output logic        resp_valid,
  input  logic        resp_ack,
  output logic        busy,
  output logic [7:0]  err_count,
  output logic [15:0] cmd_count
);

  // Handshake: a byte moves in any cycle where resp_valid & resp_ack are both high;
  // resp_valid/resp_data stay put until then, and resp_ack is ignored otherwise.

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_STREAM,
    S_WAIT_RELEASE
  } state_t;

  localparam logic [8:0] READ_LEN_W = 9'(READ_LEN);

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [63:0] cap_q, cap_d;
  logic        led_q, led_d;
  logic [7:0]  resp_data_q, resp_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [15:0] cmd_count_q, cmd_count_d;
  logic [8:0]  idx_q, idx_d;

  logic        rise;
  logic [7:0]  opcode;
  logic [8:0]  stream_len;
  logic [1:0]  err_inc;
  logic [8:0]  err_sum;
  logic [8:0]  idx_next;
  logic        unused_cap;

  assign unused_cap = ^{cap_q[63:57], cap_q[55:16]};

  function automatic logic [7:0] stream_byte(input logic [7:0] opc,
                                             input logic [7:0] base,
                                             input logic [7:0] i);
    logic [31:0] id;
    id = CHIP_ID;
    if (opc == 8'h90) return id[{i[1:0], 3'b000} +: 8];
    else              return base + i;
  endfunction

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready;
    cap_d        = cap_q;
    led_d        = led_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    cmd_count_d  = cmd_count_q;
    idx_d        = idx_q;
    err_inc      = 2'd0;

    rise       = cmd_ready & ~cmd_ready_q;
    opcode     = cap_q[7:0];
    stream_len = (opcode == 8'h90) ? 9'd4 : READ_LEN_W;
    idx_next   = idx_q + 9'd1;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          cap_d       = cmd;
          cmd_count_d = cmd_count_q + 16'd1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          8'hFF: begin
            led_d   = cap_q[56];
            state_d = S_WAIT_RELEASE;
          end
          8'h9F: state_d = S_WAIT_RELEASE;
          8'h90, 8'hB7: begin
            idx_d        = 9'd0;
            resp_valid_d = 1'b1;
            resp_data_d  = stream_byte(opcode, cap_q[15:8], 8'd0);
            state_d      = S_STREAM;
          end
          default: begin
            err_inc = err_inc + 2'd1;
            state_d = S_WAIT_RELEASE;
          end
        endcase
      end
      S_STREAM: begin
        if (resp_valid_q && resp_ack) begin
          if (idx_next == stream_len) begin
            resp_valid_d = 1'b0;
            state_d      = S_WAIT_RELEASE;
          end else begin
            idx_d       = idx_next;
            resp_data_d = stream_byte(opcode, cap_q[15:8], idx_next[7:0]);
          end
        end
      end
      S_WAIT_RELEASE: begin
        if (!cmd_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An edge arriving while a command is in flight is dropped as an overrun.
    if (rise && (state_q != S_IDLE)) err_inc = err_inc + 2'd1;

    err_sum     = {1'b0, err_count_q} + {7'd0, err_inc};
    err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b1;
      cap_q        <= 64'd0;
      led_q        <= 1'b0;
      resp_data_q  <= 8'd0;
      resp_valid_q <= 1'b0;
      err_count_q  <= 8'd0;
      cmd_count_q  <= 16'd0;
      idx_q        <= 9'd0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      cap_q        <= cap_d;
      led_q        <= led_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      err_count_q  <= err_count_d;
      cmd_count_q  <= cmd_count_d;
      idx_q        <= idx_d;
    end
  end

  assign led        = led_q;
  assign resp_data  = resp_data_q;
  assign resp_valid = resp_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign err_count  = err_count_q;
  assign cmd_count  = cmd_count_q;

endmodule
